// File: rtl/mmio_disp_io.sv
// mmio_disp_io
// Memory-mapped I/O block for the SOPC data-RAM bus. It drives an N-digit
// multiplexed seven-segment display and exposes synchronised switches and
// debounced push-buttons with sticky, write-1-to-clear rising-edge flags.
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   ce, we           bus select and write strobe (write = ce & we)
//   addr             byte address, only addr[4:2] selects a register
//   sel              byte enables for writes
//   data_i, data_o   write data / combinational read data (0 when not reading)
//   btn, switch      raw asynchronous inputs
//   an               active-low digit anodes
//   led              active-low segments, [7] = dp, [6:0] = g..a
//
// Register map (addr[4:2]): 0 DISP, 1 CTRL, 2 SW, 3 BTN_LVL, 4 BTN_EDGE,
// 5..7 read as zero and ignore writes.
module mmio_disp_io #(
  parameter int NUM_DIGITS      = 4,
  parameter int NUM_BTN         = 3,
  parameter int SW_WIDTH        = 16,
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [3:0]            sel,
  input  logic [31:0]           data_i,
  output logic [31:0]           data_o,
  input  logic [NUM_BTN-1:0]    btn,
  input  logic [SW_WIDTH-1:0]   switch,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            led
);

  localparam int DISP_W = 4 * NUM_DIGITS;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] REG_DISP     = 3'd0;
  localparam logic [2:0] REG_CTRL     = 3'd1;
  localparam logic [2:0] REG_SW       = 3'd2;
  localparam logic [2:0] REG_BTN_LVL  = 3'd3;
  localparam logic [2:0] REG_BTN_EDGE = 3'd4;

  logic [DISP_W-1:0]     disp_reg;
  logic [NUM_DIGITS-1:0] en_reg;
  logic [NUM_DIGITS-1:0] dp_reg;
  logic [SW_WIDTH-1:0]   sw_s1, sw_s2;
  logic [NUM_BTN-1:0]    btn_s1, btn_s2, btn_lvl, btn_edge;
  logic [NUM_BTN-1:0]    edge_rise, edge_clr;
  logic [DEB_W-1:0]      deb_cnt [NUM_BTN];
  logic [PRE_W-1:0]      presc;
  logic [IDX_W-1:0]      idx;

  logic [2:0]  reg_sel;
  logic        wr_en;
  logic [31:0] wmask;
  logic [31:0] ctrl_word;
  logic [31:0] disp_merged;
  logic [31:0] ctrl_merged;
  logic        unused_bits;

  assign reg_sel = addr[4:2];
  assign wr_en   = ce & we;
  assign wmask   = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};

  // CTRL as seen on the bus: enables in the low byte, decimal points from bit 8.
  always_comb begin
    ctrl_word = '0;
    ctrl_word[NUM_DIGITS-1:0] = en_reg;
    ctrl_word[8 +: NUM_DIGITS] = dp_reg;
  end

  // Byte-lane merge of write data into the current register image.
  assign disp_merged = (32'(disp_reg) & ~wmask) | (data_i & wmask);
  assign ctrl_merged = (ctrl_word & ~wmask) | (data_i & wmask);

  // Only the enabled byte lanes of the W1C mask may clear flags.
  assign edge_clr = (wr_en && reg_sel == REG_BTN_EDGE) ?
                    (data_i[NUM_BTN-1:0] & wmask[NUM_BTN-1:0]) : '0;

  // A button's level rises on exactly the edge where its debounce counter
  // expires while the synced input is high and the level is still low.
  always_comb begin
    edge_rise = '0;
    for (int b = 0; b < NUM_BTN; b++) begin
      edge_rise[b] = ~btn_lvl[b] & btn_s2[b] & (deb_cnt[b] == DEB_LAST);
    end
  end

  // Decoded addresses outside addr[4:2] and register bits above the
  // implemented width are intentionally ignored.
  assign unused_bits = ^{addr[31:5], addr[1:0], disp_merged, ctrl_merged};

  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    case (v)
      4'h0: hex7seg = 7'b0111111;
      4'h1: hex7seg = 7'b0000110;
      4'h2: hex7seg = 7'b1011011;
      4'h3: hex7seg = 7'b1001111;
      4'h4: hex7seg = 7'b1100110;
      4'h5: hex7seg = 7'b1101101;
      4'h6: hex7seg = 7'b1111101;
      4'h7: hex7seg = 7'b0000111;
      4'h8: hex7seg = 7'b1111111;
      4'h9: hex7seg = 7'b1101111;
      4'hA: hex7seg = 7'b1110111;
      4'hB: hex7seg = 7'b1111100;
      4'hC: hex7seg = 7'b0111001;
      4'hD: hex7seg = 7'b1011110;
      4'hE: hex7seg = 7'b1111001;
      default: hex7seg = 7'b1110001;
    endcase
  endfunction

  // Bus-writable registers and sticky edge flags; a new rising edge takes
  // priority over a simultaneous clear of the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_reg <= '0;
      en_reg   <= '1;
      dp_reg   <= '0;
      btn_edge <= '0;
    end else begin
      if (wr_en && reg_sel == REG_DISP) begin
        disp_reg <= disp_merged[DISP_W-1:0];
      end
      if (wr_en && reg_sel == REG_CTRL) begin
        en_reg <= ctrl_merged[NUM_DIGITS-1:0];
        dp_reg <= ctrl_merged[8 +: NUM_DIGITS];
      end
      btn_edge <= (btn_edge & ~edge_clr) | edge_rise;
    end
  end

  // Two-flop synchronisers and per-button debounce counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      btn_s1  <= '0;
      btn_s2  <= '0;
      btn_lvl <= '0;
      for (int b = 0; b < NUM_BTN; b++) begin
        deb_cnt[b] <= '0;
      end
    end else begin
      sw_s1  <= switch;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      for (int b = 0; b < NUM_BTN; b++) begin
        if (btn_s2[b] == btn_lvl[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == DEB_LAST) begin
          btn_lvl[b] <= btn_s2[b];
          deb_cnt[b] <= '0;
        end else begin
          deb_cnt[b] <= deb_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Digit scanner; an/led are registered from the index and registers as
  // they stand before this edge, so changes show one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
      an    <= '1;
      led   <= 8'hFF;
    end else begin
      if (presc == PRE_LAST) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      an  <= en_reg[idx] ? ~(NUM_DIGITS'(1) << idx) : '1;
      led <= {~dp_reg[idx], ~hex7seg(disp_reg[4*idx +: 4])};
    end
  end

  // Combinational read mux.
  always_comb begin
    data_o = '0;
    if (ce && !we) begin
      case (reg_sel)
        REG_DISP:     data_o = 32'(disp_reg);
        REG_CTRL:     data_o = ctrl_word;
        REG_SW:       data_o = 32'(sw_s2);
        REG_BTN_LVL:  data_o = 32'(btn_lvl);
        REG_BTN_EDGE: data_o = 32'(btn_edge);
        default:      data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_disp_io.sv
// tb_mmio_disp_io
// Self-checking bench for mmio_disp_io with small scan/debounce constants.
// A behavioural model (frame position from an edge count, debounce as a run
// length of mismatched synced samples, byte-lane writes) predicts an, led
// and data_o every cycle; table vectors and hand sequences add fixed
// expectations for the register map and the multi-cycle corner cases.
module tb_mmio_disp_io;

  localparam int ND  = 4;
  localparam int NB  = 3;
  localparam int SWW = 16;
  localparam int SD  = 4;
  localparam int DC  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            ce, we;
  logic [31:0]     addr, data_i, data_o;
  logic [3:0]      sel;
  logic [NB-1:0]   btn;
  logic [SWW-1:0]  switch;
  logic [ND-1:0]   an;
  logic [7:0]      led;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmio_disp_io #(
    .NUM_DIGITS(ND), .NUM_BTN(NB), .SW_WIDTH(SWW),
    .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .btn(btn), .switch(switch),
    .an(an), .led(led)
  );

  // Reference model state
  logic [15:0]    m_disp;
  logic [3:0]     m_en, m_dp;
  logic [NB-1:0]  m_b1, m_b2, m_lvl, m_edge;
  logic [SWW-1:0] m_sw1, m_sw2;
  int             m_run [NB];
  int             m_tick;
  logic [3:0]     m_an;
  logic [7:0]     m_led;

  typedef struct {
    logic        ce;
    logic        we;
    logic [2:0]  a;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_rd;
  } vec_t;

  function automatic logic [6:0] segOf(input logic [3:0] v);
    case (v)
      4'h0: segOf = 7'h3F; 4'h1: segOf = 7'h06; 4'h2: segOf = 7'h5B; 4'h3: segOf = 7'h4F;
      4'h4: segOf = 7'h66; 4'h5: segOf = 7'h6D; 4'h6: segOf = 7'h7D; 4'h7: segOf = 7'h07;
      4'h8: segOf = 7'h7F; 4'h9: segOf = 7'h6F; 4'hA: segOf = 7'h77; 4'hB: segOf = 7'h7C;
      4'hC: segOf = 7'h39; 4'hD: segOf = 7'h5E; 4'hE: segOf = 7'h79; default: segOf = 7'h71;
    endcase
  endfunction

  function automatic logic [31:0] modelRead(input logic [2:0] a);
    case (a)
      3'd0: modelRead = {16'h0, m_disp};
      3'd1: modelRead = {20'h0, m_dp, 4'h0, m_en};
      3'd2: modelRead = {16'h0, m_sw2};
      3'd3: modelRead = {29'h0, m_lvl};
      3'd4: modelRead = {29'h0, m_edge};
      default: modelRead = 32'h0;
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  task automatic modelEdge();
    int d;
    logic [NB-1:0] rise, clr;
    if (rst) begin
      m_disp = '0; m_en = '1; m_dp = '0;
      m_b1 = '0; m_b2 = '0; m_lvl = '0; m_edge = '0;
      m_sw1 = '0; m_sw2 = '0; m_tick = 0;
      for (int b = 0; b < NB; b++) m_run[b] = 0;
      m_an = '1; m_led = 8'hFF;
    end else begin
      d = (m_tick / SD) % ND;
      m_an  = m_en[d] ? ~(4'b0001 << d) : 4'hF;
      m_led = {~m_dp[d], ~segOf(m_disp[4*d +: 4])};
      m_tick++;
      rise = '0;
      for (int b = 0; b < NB; b++) begin
        if (m_b2[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == DC) begin
            m_lvl[b] = m_b2[b];
            m_run[b] = 0;
            rise[b]  = m_lvl[b];
          end
        end else begin
          m_run[b] = 0;
        end
      end
      clr = '0;
      if (ce && we) begin
        for (int i = 0; i < 4; i++) begin
          if (sel[i]) begin
            case (addr[4:2])
              3'd0: if (i < 2) m_disp[8*i +: 8] = data_i[8*i +: 8];
              3'd1: begin
                if (i == 0) m_en = data_i[3:0];
                if (i == 1) m_dp = data_i[11:8];
              end
              3'd4: if (i == 0) clr = data_i[NB-1:0];
              default: ;
            endcase
          end
        end
      end
      m_edge = (m_edge & ~clr) | rise;
      m_sw2 = m_sw1; m_sw1 = switch;
      m_b2 = m_b1;   m_b1 = btn;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model, edge, then compare all outputs against the model.
  task automatic applyStimulus();
    logic [31:0] exp_rd;
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput("an", 32'(an), 32'(m_an));
    checkOutput("led", 32'(led), 32'(m_led));
    exp_rd = (ce && !we) ? modelRead(addr[4:2]) : 32'h0;
    checkOutput("data_o", data_o, exp_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic setBus(input logic c, input logic w, input logic [2:0] a,
                        input logic [3:0] s, input logic [31:0] d);
    ce = c; we = w; addr = {27'h0, a, 2'b00}; sel = s; data_i = d;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [14];
    bit   found;
    int   cnt;
    int   bi;

    vecs[0]  = '{1'b1, 1'b1, 3'd0, 4'b0001, 32'h0000_0055, 32'h0000_F355};
    vecs[1]  = '{1'b1, 1'b1, 3'd0, 4'b1100, 32'hFFFF_0000, 32'h0000_F355};
    vecs[2]  = '{1'b1, 1'b1, 3'd0, 4'b0010, 32'h0000_AB00, 32'h0000_AB55};
    vecs[3]  = '{1'b1, 1'b1, 3'd0, 4'b1111, 32'h0000_F380, 32'h0000_F380};
    vecs[4]  = '{1'b1, 1'b1, 3'd1, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0F0F};
    vecs[5]  = '{1'b1, 1'b1, 3'd1, 4'b0001, 32'h0000_0000, 32'h0000_0F00};
    vecs[6]  = '{1'b1, 1'b1, 3'd1, 4'b0010, 32'h0000_0000, 32'h0000_0000};
    vecs[7]  = '{1'b1, 1'b1, 3'd1, 4'b1111, 32'h0000_000F, 32'h0000_000F};
    vecs[8]  = '{1'b1, 1'b1, 3'd6, 4'b1111, 32'h1234_5678, 32'h0000_0000};
    vecs[9]  = '{1'b1, 1'b1, 3'd5, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[10] = '{1'b1, 1'b1, 3'd3, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[11] = '{1'b1, 1'b1, 3'd2, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[12] = '{1'b1, 1'b1, 3'd7, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[13] = '{1'b0, 1'b1, 3'd0, 4'b1111, 32'h0000_1111, 32'h0000_F380};

    // Reset state and first valid display cycle
    rst = 1'b1; btn = '0; switch = '0;
    setBus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
    idle(3);
    checkOutput("rst_an", 32'(an), 32'hF);
    checkOutput("rst_led", 32'(led), 32'hFF);
    rst = 1'b0;
    setBus(1'b1, 1'b0, 3'd1, 4'h0, 32'h0);
    applyStimulus();
    checkOutput("first_an", 32'(an), 32'hE);
    checkOutput("first_led", 32'(led), 32'hC0);
    checkOutput("rst_ctrl", data_o, 32'h0000_000F);
    setBus(1'b1, 1'b0, 3'd4, 4'h0, 32'h0);
    applyStimulus();
    checkOutput("rst_btn_edge", data_o, 32'h0);

    // Scan of DISP = 0xF380: digits 0,8,3,F
    setBus(1'b1, 1'b1, 3'd0, 4'b1111, 32'h0000_F380);
    applyStimulus();
    setBus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus();
      if (an == 4'b0111) found = 1'b1;
    end
    checkOutput("scan_reach_d3", 32'(found), 32'h1);
    checkOutput("scan_led_d3", 32'(led), 32'h8E);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      applyStimulus();
      if (an != 4'b0111) found = 1'b1;
    end
    checkOutput("scan_wrap", 32'(an), 32'hE);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus();
      if (an == 4'b1101) found = 1'b1;
    end
    checkOutput("scan_led_d1", 32'(led), 32'h80);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus();
      if (an == 4'b0111) cnt++;
    end
    checkOutput("scan_slot_len", 32'(cnt), 32'd4);

    // Register map vectors: one bus operation, then read back the same address
    for (int i = 0; i < 14; i++) begin
      setBus(vecs[i].ce, vecs[i].we, vecs[i].a, vecs[i].sel, vecs[i].data);
      applyStimulus();
      setBus(1'b1, 1'b0, vecs[i].a, 4'h0, 32'h0);
      applyStimulus();
      checkOutput($sformatf("vec%0d", i), data_o, vecs[i].exp_rd);
    end

    // CTRL = 0x10D: digit 1 blanked, dp on digit 0
    setBus(1'b1, 1'b1, 3'd1, 4'b1111, 32'h0000_010D);
    applyStimulus();
    setBus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
    applyStimulus();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus();
      if (an == 4'b1111) cnt++;
    end
    checkOutput("blank_slots", 32'(cnt), 32'd4);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus();
      if (an == 4'b1110) found = 1'b1;
    end
    checkOutput("dp0_reach", 32'(found), 32'h1);
    checkOutput("dp0_led7", 32'(led[7]), 32'h0);

    // Button step on btn[0]: level and flag rise on edge 10
    setBus(1'b1, 1'b0, 3'd3, 4'h0, 32'h0);
    btn = 3'b001;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus();
      if (k == 9)  checkOutput("lvl_edge9", data_o, 32'h0);
      if (k == 10) checkOutput("lvl_edge10", data_o, 32'h1);
    end
    btn = 3'b000;
    setBus(1'b1, 1'b0, 3'd4, 4'h0, 32'h0);
    applyStimulus();
    checkOutput("edge_flag0", data_o, 32'h1);
    idle(12);
    setBus(1'b1, 1'b0, 3'd3, 4'h0, 32'h0);
    applyStimulus();
    checkOutput("lvl_released", data_o, 32'h0);

    // Short glitch on btn[1]
    btn = 3'b010;
    idle(5);
    btn = 3'b000;
    idle(12);
    checkOutput("glitch_lvl", data_o, 32'h0);
    setBus(1'b1, 1'b0, 3'd4, 4'h0, 32'h0);
    applyStimulus();
    checkOutput("glitch_edge", data_o, 32'h1);

    // W1C: disabled lane does not clear, enabled lane does
    setBus(1'b1, 1'b1, 3'd4, 4'b0000, 32'h0000_0001);
    applyStimulus();
    setBus(1'b1, 1'b0, 3'd4, 4'h0, 32'h0);
    applyStimulus();
    checkOutput("w1c_sel0", data_o, 32'h1);
    setBus(1'b1, 1'b1, 3'd4, 4'b0001, 32'h0000_0001);
    applyStimulus();
    setBus(1'b1, 1'b0, 3'd4, 4'h0, 32'h0);
    applyStimulus();
    checkOutput("w1c_clear", data_o, 32'h0);

    // W1C on the same edge a new rising edge sets the bit: set wins
    setBus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
    btn = 3'b001;
    idle(9);
    setBus(1'b1, 1'b1, 3'd4, 4'b0001, 32'h0000_0001);
    applyStimulus();
    setBus(1'b1, 1'b0, 3'd4, 4'h0, 32'h0);
    applyStimulus();
    checkOutput("w1c_set_wins", data_o, 32'h1);

    // Switch synchronisation latency and an unmapped address
    setBus(1'b1, 1'b0, 3'd2, 4'h0, 32'h0);
    switch = 16'hA5A5;
    applyStimulus();
    checkOutput("sw_edge1", data_o, 32'h0);
    applyStimulus();
    checkOutput("sw_edge2", data_o, 32'h0000_A5A5);
    setBus(1'b1, 1'b0, 3'd6, 4'h0, 32'h0);
    applyStimulus();
    checkOutput("addr6_read", data_o, 32'h0);

    // Reset mid-frame
    setBus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
    idle(3);
    rst = 1'b1;
    applyStimulus();
    checkOutput("midrst_an", 32'(an), 32'hF);
    checkOutput("midrst_led", 32'(led), 32'hFF);
    rst = 1'b0;
    setBus(1'b1, 1'b0, 3'd0, 4'h0, 32'h0);
    applyStimulus();
    checkOutput("midrst_idx0_an", 32'(an), 32'hE);
    checkOutput("midrst_led0", 32'(led), 32'hC0);
    checkOutput("midrst_disp", data_o, 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      ce     = ($urandom_range(0, 3) != 0);
      we     = ($urandom_range(0, 2) == 0);
      addr   = $urandom;
      sel    = 4'($urandom);
      data_i = $urandom;
      if ($urandom_range(0, 5) == 0) switch = 16'($urandom);
      if ($urandom_range(0, 11) == 0) begin
        bi = $urandom_range(0, NB - 1);
        btn[bi] = ~btn[bi];
      end
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_disp_io.md
# mmio_disp_io

Parametrised memory-mapped I/O controller on the data-RAM bus of the minimal SOPC. It gives the OpenMIPS core word-addressed registers for an N-digit multiplexed seven-segment display, synchronised switches and debounced push-buttons with sticky, write-1-to-clear edge flags. It replaces the fixed A/B/calc, 4-digit handling inside the data RAM with width, digit-count and timing parameters, and adds debounce, edge capture and per-digit blanking.

## Interface
- NUM_DIGITS, 4, display digits; legal range 1..8.
- NUM_BTN, 3, push-buttons; legal range 1..32.
- SW_WIDTH, 16, switch count; legal range 1..32.
- SCAN_DIV, 50000, clk cycles per digit slot; minimum 2.
- DEBOUNCE_CYCLES, 100000, stable cycles required before the debounced level changes; minimum 2.
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous reset, active-high.
- ce  in  1  block select, from bus decode.
- we  in  1  write strobe, qualified by ce.
- addr  in  32  byte address; only addr[4:2] is decoded.
- sel  in  4  byte enables for writes.
- data_i  in  32  write data.
- data_o  out  32  read data.
- btn  in  NUM_BTN  raw, asynchronous, active-high buttons.
- switch  in  SW_WIDTH  raw, asynchronous switches.
- an  out  NUM_DIGITS  digit anodes, active-low.
- led  out  8  active-low segments: [7] = dp, [6:0] = g..a.

## Operation
- Register map, by addr[4:2]:
  - 0 DISP: R/W; nibble k (bits 4k+3:4k) is the hex value of digit k; bits above 4*NUM_DIGITS read 0.
  - 1 CTRL: R/W; [NUM_DIGITS-1:0] digit enable; [8+NUM_DIGITS-1:8] decimal points.
  - 2 SW: RO; the 2-flop-synchronised switch value, zero-extended.
  - 3 BTN_LVL: RO; debounced button levels.
  - 4 BTN_EDGE: sticky rising-edge flags; write 1 clears the bit (W1C).
  - 5..7: reads return 0; writes are ignored.
- Writes occur on the posedge when ce=1 and we=1. Byte lane i is written only if sel[i]=1. This applies to DISP, CTRL and the BTN_EDGE clear mask.
- Reads are combinational: data_o = the addressed register when ce=1 and we=0, otherwise 0.
- Scanner:
  - The prescaler counts 0..SCAN_DIV-1.
  - At terminal count the digit index advances; it wraps from NUM_DIGITS-1 to 0.
- Outputs are registered every cycle from the current index and registers:
  - an = ~(1<<idx) if enable[idx]=1; otherwise all ones.
  - led[6:0] = ~hex7seg(nibble idx); led[7] = ~dp[idx].
  - hex7seg(0)=0111111, hex7seg(8)=1111111, hex7seg(F)=1110001.
- Debounce, per button:
  - Raw input passes through a 2-flop synchroniser.
  - The counter clears whenever the synced value equals the level.
  - Otherwise the counter increments. When the counter equals DEBOUNCE_CYCLES-1 and the mismatch persists, level <= synced and the counter clears.
- Edge flag:
  - The bit sets on the edge where level goes 0->1.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- Reset values:
  - DISP = 0, CTRL enable = all ones, dp = 0.
  - BTN_LVL = 0, BTN_EDGE = 0.
  - Synchronisers = 0, counters = 0, idx = 0.
  - an = all ones, led = 8'hFF.
- Reset asserted mid-scan or mid-debounce returns everything to the reset values on that edge. No partial state survives.

## Timing
- Register write -> an/led: the new value is visible 1 cycle after the write edge, provided that digit is currently selected.
- Digit slot is exactly SCAN_DIV cycles; full frame = NUM_DIGITS*SCAN_DIV cycles.
- Switch -> SW readable: 2 edges after the input changes.
- A clean button step that lands before edge 0 updates BTN_LVL and BTN_EDGE at edge 2+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES synced cycles never changes the level.
- First valid an/led appear 1 cycle after rst deasserts.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, SCAN_DIV=4, DEBOUNCE_CYCLES=8.

- Reset check: after rst, an=1111 and led=FF for 1 cycle; then an=1110, led=8'b1100_0000; reads give CTRL=0x0000000F and BTN_EDGE=0.
- Write DISP=0x0000F380 with sel=4'b1111. Required: digits 0..3 show 0,8,3,F; an cycles 1110,1101,1011,0111 every 4 cycles, wrapping to 1110. Then write sel=4'b0001 with data 0x55 -> DISP reads 0x0000F355.
- Write CTRL=0x0000010D. Required: the digit-1 slot drives an=1111; digit 0 has led[7]=0.
- Button step held 10 cycles, then released. Required: BTN_LVL and BTN_EDGE bit 0 become 1 at edge 10 after the step. A 5-cycle pulse on btn[1] leaves both at 0.
- W1C clear: write BTN_EDGE=1 with sel=0001 -> bit clears. Repeat the write on the same edge that a new rising edge sets the bit -> bit reads 1.
- switch=0xA5A5 -> SW reads 0x0000A5A5 from edge 2. Address 6 reads 0. Assert rst mid-frame -> idx=0 and an=1111 on the next cycle.
